// File: rtl/pwm_ctrl_pkg.sv
// Shared definitions for the PWM breathing sequencer: FSM state type and
// peripheral register map.
package pwm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_PERIOD,
    ST_WR_DUTY0,
    ST_RISE,
    ST_HOLD_HI,
    ST_FALL,
    ST_HOLD_LO,
    ST_STOPPING
  } pwm_state_e;

  localparam logic PWM_ADDR_PERIOD = 1'b0;
  localparam logic PWM_ADDR_DUTY   = 1'b1;

endpackage

// File: rtl/pwm_breath_ctrl_if.sv
// Write port of the two-register PWM peripheral plus its period carry-out.
interface pwm_breath_ctrl_if #(parameter int DW = 32);
  logic          addr;
  logic [DW-1:0] wrdata;
  logic          write;
  logic          co;

  modport master (output addr, wrdata, write, input co);
  modport slave  (input addr, wrdata, write, output co);
endinterface

// File: rtl/pwm_sat_step.sv
// One duty step in DW+1 bits: add clamps at full, subtract clamps at zero.
module pwm_sat_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] step,
  input  logic [DW-1:0] full,
  input  logic          dec,
  output logic [DW-1:0] nxt
);

  logic [DW:0] sum;
  logic [DW:0] dif;

  always_comb begin
    sum = {1'b0, cur} + {1'b0, step};
    dif = {1'b0, cur} - {1'b0, step};
    if (dec) nxt = dif[DW] ? '0 : dif[DW-1:0];
    else     nxt = (sum > {1'b0, full}) ? full : sum[DW-1:0];
  end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-waveform sequencer mastering the PWM peripheral write port.
// Define PWM_BREATH_HOLD_EN to build the peak/zero hold states.
module pwm_breath_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [DW-1:0]     period_cfg,
  input  logic [DW-1:0]     step_cfg,
  input  logic [CW-1:0]     hold_cfg,
  input  logic [CW-1:0]     breaths_cfg,
  output logic              busy,
  output logic              done,
  pwm_breath_ctrl_if.master pwm
);

  localparam logic [DW-1:0] ONE_D = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

  pwm_state_e    state, nstate;
  logic [DW-1:0] duty_q, duty_n, full_q, step_q, nxt_duty;
  logic [CW-1:0] breaths_q, bcnt_q, bcnt_n;
  logic          addr_q, addr_n, write_q, write_n;
  logic [DW-1:0] wrdata_q, wrdata_n;
  logic          busy_n, done_n, ld_cfg, last_breath;

`ifdef PWM_BREATH_HOLD_EN
  logic [CW-1:0] hold_q, hcnt_q, hcnt_n;
  logic          hold_exp;
  assign hold_exp = (hold_q == '0) || (pwm.co && (hcnt_q + ONE_C == hold_q));
`else
  logic unused_hold;
  assign unused_hold = ^hold_cfg;
`endif

  pwm_sat_step #(.DW(DW)) u_step (
    .cur  (duty_q),
    .step (step_q),
    .full (full_q),
    .dec  (state == ST_FALL),
    .nxt  (nxt_duty)
  );

  assign last_breath = (breaths_q != '0) && (bcnt_q + ONE_C == breaths_q);

  always_comb begin
    nstate   = state;
    duty_n   = duty_q;
    bcnt_n   = bcnt_q;
    addr_n   = addr_q;
    wrdata_n = wrdata_q;
    write_n  = 1'b0;
    ld_cfg   = 1'b0;
`ifdef PWM_BREATH_HOLD_EN
    hcnt_n   = hcnt_q;
`endif
    case (state)
      ST_IDLE: if (start && !stop) begin
        ld_cfg   = 1'b1;
        duty_n   = '0;
        bcnt_n   = '0;
        write_n  = 1'b1;
        addr_n   = PWM_ADDR_PERIOD;
        wrdata_n = period_cfg;
        nstate   = ST_WR_PERIOD;
      end
      ST_WR_PERIOD: begin
        write_n  = 1'b1;
        addr_n   = PWM_ADDR_DUTY;
        wrdata_n = '0;
        nstate   = ST_WR_DUTY0;
      end
      ST_WR_DUTY0: nstate = ST_RISE;
      ST_RISE: if (pwm.co) begin
        duty_n   = nxt_duty;
        write_n  = 1'b1;
        addr_n   = PWM_ADDR_DUTY;
        wrdata_n = nxt_duty;
        if (nxt_duty == full_q) begin
`ifdef PWM_BREATH_HOLD_EN
          hcnt_n = '0;
          nstate = ST_HOLD_HI;
`else
          nstate = ST_FALL;
`endif
        end
      end
      ST_FALL: if (pwm.co) begin
        duty_n   = nxt_duty;
        write_n  = 1'b1;
        addr_n   = PWM_ADDR_DUTY;
        wrdata_n = nxt_duty;
        if (nxt_duty == '0) begin
`ifdef PWM_BREATH_HOLD_EN
          hcnt_n = '0;
          nstate = ST_HOLD_LO;
`else
          bcnt_n = bcnt_q + ONE_C;
          nstate = last_breath ? ST_IDLE : ST_RISE;
`endif
        end
      end
`ifdef PWM_BREATH_HOLD_EN
      ST_HOLD_HI: begin
        if (pwm.co) hcnt_n = hcnt_q + ONE_C;
        if (hold_exp) begin
          hcnt_n = '0;
          nstate = ST_FALL;
        end
      end
      ST_HOLD_LO: begin
        if (pwm.co) hcnt_n = hcnt_q + ONE_C;
        if (hold_exp) begin
          hcnt_n = '0;
          bcnt_n = bcnt_q + ONE_C;
          nstate = last_breath ? ST_IDLE : ST_RISE;
        end
      end
`endif
      ST_STOPPING: nstate = ST_IDLE;
      default:     nstate = ST_IDLE;
    endcase
    // Abort beats any step or breath-end decision taken above.
    if (stop && state != ST_IDLE && state != ST_STOPPING) begin
      duty_n   = '0;
      write_n  = 1'b1;
      addr_n   = PWM_ADDR_DUTY;
      wrdata_n = '0;
      nstate   = ST_STOPPING;
    end
    busy_n = (nstate != ST_IDLE);
    done_n = (nstate == ST_IDLE) && (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      duty_q    <= '0;
      full_q    <= '0;
      step_q    <= ONE_D;
      breaths_q <= '0;
      bcnt_q    <= '0;
      addr_q    <= 1'b0;
      wrdata_q  <= '0;
      write_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state    <= nstate;
      duty_q   <= duty_n;
      bcnt_q   <= bcnt_n;
      addr_q   <= addr_n;
      wrdata_q <= wrdata_n;
      write_q  <= write_n;
      busy     <= busy_n;
      done     <= done_n;
      if (ld_cfg) begin
        full_q    <= (&period_cfg) ? period_cfg : period_cfg + ONE_D;
        step_q    <= (step_cfg == '0) ? ONE_D : step_cfg;
        breaths_q <= breaths_cfg;
      end
    end
  end

`ifdef PWM_BREATH_HOLD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      hcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_n;
      if (ld_cfg) hold_q <= hold_cfg;
    end
  end
`endif

  assign pwm.addr   = addr_q;
  assign pwm.wrdata = wrdata_q;
  assign pwm.write  = write_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Bench for pwm_breath_ctrl: a small PWM stand-in supplies co, every write is
// logged and compared with a duty list derived from the ramp rules.
module tb_pwm_breath_ctrl;
  localparam int DW = 32;
  localparam int CW = 16;
`ifdef PWM_BREATH_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic [DW-1:0] period_cfg = '0, step_cfg = '0;
  logic [CW-1:0] hold_cfg = '0, breaths_cfg = '0;
  logic          busy, done;

  pwm_breath_ctrl_if #(.DW(DW)) pif ();

  pwm_breath_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .period_cfg(period_cfg), .step_cfg(step_cfg), .hold_cfg(hold_cfg),
    .breaths_cfg(breaths_cfg), .busy(busy), .done(done), .pwm(pif)
  );

  always #5 clk = ~clk;

  // PWM stand-in: huge periods are shortened to 16 cycles so long ramps finish
  logic [DW-1:0] per_reg;
  logic [4:0]    pcnt, lim;
  assign lim    = (per_reg > 32'd15) ? 5'd15 : per_reg[4:0];
  assign pif.co = (pcnt == lim);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_reg <= '0;
      pcnt    <= '0;
    end else begin
      if (pif.write && pif.addr == 1'b0) per_reg <= pif.wrdata;
      pcnt <= (pcnt >= lim) ? 5'd0 : pcnt + 5'd1;
    end
  end

  typedef struct { logic a; logic [DW-1:0] d; int cyc; int con; } wr_t;
  typedef struct { logic a; logic [DW-1:0] d; int con; } ex_t;
  wr_t got[$];
  ex_t exq[$];
  int  cyc = 0, co_since = 0, done_n = 0, done_cyc = 0, done_co = 0;
  int  checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // co pulses are counted between writes, excluding the write cycles themselves
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_co  = co_since;
      chk("done_busy", busy, 0);
    end
    if (pif.write) begin
      got.push_back('{pif.addr, pif.wrdata, cyc, co_since});
      co_since = 0;
    end else if (pif.co) co_since++;
  endtask

  // Expected writes: period, zero, then per breath a clamped ramp up and down.
  // con = co pulses expected before each duty write (-1: not checked).
  function automatic void build(input longint unsigned per, input longint unsigned stp,
                                input int hold, input int nb);
    longint unsigned full, s, d;
    int h;
    exq.delete();
    full = (per == 64'hFFFF_FFFF) ? per : per + 1;
    s    = (stp == 0) ? 1 : stp;
    h    = HOLD_ON ? hold + 1 : 1;
    exq.push_back('{1'b0, DW'(per), -1});
    exq.push_back('{1'b1, '0, -1});
    for (int b = 0; b < nb; b++) begin
      d = 0;
      for (int n = 0; d != full; n++) begin
        d = (d + s > full) ? full : d + s;
        exq.push_back('{1'b1, DW'(d), (n == 0 && b > 0) ? h : 1});
      end
      for (int n = 0; d != 0; n++) begin
        d = (d > s) ? d - s : 0;
        exq.push_back('{1'b1, DW'(d), (n == 0) ? h : 1});
      end
    end
  endfunction

  task automatic compare(input string tag, input int n, input bit cco);
    for (int i = 0; i < n && i < got.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), got[i].a, exq[i].a);
      chk($sformatf("%s_data%0d", tag, i), got[i].d, exq[i].d);
      if (cco && exq[i].con >= 0) chk($sformatf("%s_co%0d", tag, i), got[i].con, exq[i].con);
    end
  endtask

  task automatic run(input logic [DW-1:0] per, input logic [DW-1:0] stp, input int hold,
                     input int nb, input bit cco, input bit poke);
    int s;
    build(per, stp, hold, nb);
    got.delete();
    done_n      = 0;
    period_cfg  = per;
    step_cfg    = stp;
    hold_cfg    = CW'(hold);
    breaths_cfg = CW'(nb);
    start       = 1'b1;
    s           = cyc;
    tick();
    start       = 1'b0;
    period_cfg  = $urandom;
    step_cfg    = $urandom;
    hold_cfg    = CW'($urandom);
    breaths_cfg = CW'($urandom);
    chk("busy_t1", busy, 1);
    for (int k = 0; k < 20000 && done_n == 0; k++) begin
      start = poke && (k == 12);
      tick();
    end
    start = 1'b0;
    chk("done_seen", done_n, 1);
    repeat (3) tick();
    chk("done_once", done_n, 1);
    chk("idle_busy", busy, 0);
    chk("nwr", got.size(), exq.size());
    compare("wr", exq.size(), cco);
    if (got.size() >= 2) begin
      chk("wr0_cyc", got[0].cyc, s + 1);
      chk("wr1_cyc", got[1].cyc, s + 2);
      chk("done_gap", done_cyc > got[got.size()-1].cyc, HOLD_ON);
      if (cco) chk("done_hold", (done_cyc == got[got.size()-1].cyc) ? -1 : done_co,
                   HOLD_ON ? hold : -1);
    end
  endtask

  initial begin
    int w;
    repeat (2) tick();
    chk("rst_write", pif.write, 0);
    chk("rst_addr", pif.addr, 0);
    chk("rst_wrdata", pif.wrdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    run(32'd9, 32'd3, 2, 1, 1'b1, 1'b1);
    run(32'd4, 32'd10, 1, 1, 1'b1, 1'b0);
    run(32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1'b1, 1'b0);
    run(32'd0, 32'd0, 1, 2, 1'b0, 1'b0);

    // endless breathing, abort right after the first write of the fourth fall
    build(3, 1, 1, 4);
    got.delete();
    done_n = 0;
    period_cfg = 32'd3; step_cfg = 32'd1; hold_cfg = 16'd1; breaths_cfg = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3000 && got.size() < 31; k++) tick();
    chk("stop_reach", got.size(), 31);
    w = cyc;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_nwr", got.size(), 32);
    if (got.size() == 32) begin
      chk("stop_a", got[31].a, 1);
      chk("stop_d", got[31].d, 0);
      chk("stop_cyc", got[31].cyc, w + 1);
    end
    chk("stop_busy1", busy, 1);
    tick();
    chk("stop_done", done, 1);
    chk("stop_busy2", busy, 0);
    repeat (30) tick();
    chk("stop_quiet", got.size(), 32);
    chk("stop_done1", done_n, 1);
    compare("stp", 31, 1'b1);

    // start together with stop in IDLE does nothing
    got.delete();
    done_n = 0;
    period_cfg = 32'd5; step_cfg = 32'd2;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    repeat (20) tick();
    chk("ss_nwr", got.size(), 0);
    chk("ss_busy", busy, 0);
    chk("ss_done", done_n, 0);

    // reset while a write is on the bus
    got.delete();
    period_cfg = 32'd9; step_cfg = 32'd3; hold_cfg = 16'd0; breaths_cfg = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500 && got.size() < 4; k++) tick();
    chk("rstm_pre_wr", pif.write, 1);
    rst_n = 1'b0;
    #1;
    chk("rstm_write", pif.write, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_done", done, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("rstm_idle", busy, 0);
    chk("rstm_nwr", got.size(), 4);

    for (int r = 0; r < 6; r++)
      run($urandom_range(1, 12), $urandom_range(0, 14), $urandom_range(0, 3),
          $urandom_range(1, 3), 1'b1, r[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_breath_ctrl.md
# pwm_breath_ctrl

Bus-master sequencer that drives the two-register PWM peripheral (period at word 0, duty at word 1) to produce a repeating "breathing" waveform. Ramps duty from 0 to full scale and back in programmable steps, one step per PWM period (on the peripheral's `co`), with optional holds at the peak and at zero. Sits between the control logic (or a CPU-written config register) and the PWM peripheral's write port; it is the only writer of that peripheral while busy.

## Interface
- `DW`, 32, PWM register/data width
- `CW`, 16, width of breath-count and hold-count fields
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a sequence; sampled only in IDLE
- `stop`  in  1  one-cycle request to abort; forces duty to 0, then IDLE
- `period_cfg`  in  DW  PWM period value (counter max), latched on accepted start
- `step_cfg`  in  DW  duty increment/decrement per PWM period, latched on start
- `hold_cfg`  in  CW  PWM periods to hold at peak and at zero, latched on start
- `breaths_cfg`  in  CW  number of full breaths; 0 = run until stop
- `co`  in  1  PWM carry-out, high one cycle per period
- `addr`  out  1  peripheral register select (0 period, 1 duty)
- `wrdata`  out  DW  peripheral write data
- `write`  out  1  peripheral write strobe, one cycle per write
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on return to IDLE

## Operation
- States: IDLE, WR_PERIOD, WR_DUTY0, RISE, HOLD_HI, FALL, HOLD_LO, STOPPING.
- IDLE: `start` latches all cfg inputs, clears duty and breath counter -> WR_PERIOD.
- WR_PERIOD: write `period_cfg` to addr 0 -> WR_DUTY0. WR_DUTY0: write 0 to addr 1 -> RISE.
- RISE: on each `co`, duty = min(duty + step, FULL); write duty. When written duty == FULL -> HOLD_HI.
- FULL = period + 1, computed in DW+1 bits, saturated to 2^DW-1. Sums/differences computed in DW+1 bits, never wrap.
- HOLD_HI: count `co` pulses; after `hold_cfg` pulses -> FALL (hold_cfg = 0: next cycle -> FALL).
- FALL: on each `co`, duty = max(duty - step, 0); write duty. When written duty == 0 -> HOLD_LO.
- HOLD_LO: same counting as HOLD_HI; then increment breath counter; if `breaths_cfg` != 0 and counter == `breaths_cfg` -> IDLE with `done`; else -> RISE.
- `step_cfg` = 0 is treated as 1.
- `stop` in any non-IDLE state -> STOPPING: write 0 to addr 1 -> IDLE with `done`. `stop` in IDLE ignored.
- `start` while busy ignored. `start` and `stop` in same IDLE cycle: stop wins, start ignored.
- `period_cfg` = 0: `co` high every cycle; sequence advances one step per cycle, FULL = 1.

## Timing
- All outputs registered. Reset values: `addr` 0, `wrdata` 0, `write` 0, `busy` 0, `done` 0; state IDLE.
- Start accepted at cycle t: period write at t+1, duty-0 write at t+2, `busy` high from t+1.
- `co` high at cycle t in RISE/FALL: `write` with new duty at t+1; new duty takes effect from the next PWM period.
- `co` arriving in the same cycle as a write from WR_DUTY0 is ignored (RISE starts listening the cycle after).
- `stop` at cycle t: zero-duty write at t+1, `done` and `busy` low at t+2.
- `done` high for exactly one cycle, coincident with the first IDLE cycle.
- Reset mid-sequence: outputs drop immediately, no zero-duty write issued (PWM peripheral is reset by the same system reset).

## Configuration
- `PWM_BREATH_HOLD_EN` defined: HOLD_HI/HOLD_LO and hold counter built as above.
- Undefined: hold states and counter removed, `hold_cfg` ignored; RISE -> FALL directly after FULL write, FALL -> breath accounting directly after zero write.

## Structure
- Shared package `pwm_ctrl_pkg`: state enum type, register address constants `PWM_ADDR_PERIOD` = 0, `PWM_ADDR_DUTY` = 1.
- One sub-module `pwm_sat_step`: combinational DW+1-bit saturating add/sub against a FULL bound, reused for RISE and FALL.

## Test plan
- period 9, step 3, hold 2, breaths 1 -> writes: addr0=9, addr1=0, then duty 3,6,9,10, two `co` held, 7,4,1,0, two `co` held, `done` pulse, IDLE.
- period 4, step 10 -> first RISE write saturates to 5 (FULL), next FALL write 0.
- breaths 0, run 3 breaths, pulse `stop` mid-FALL -> zero-duty write next cycle, `done` one cycle later, no further writes.
- `start` while busy and `start`+`stop` together in IDLE -> no effect, no writes, `busy` stays as before.
- Assert `rst_n` low mid-RISE -> `write`, `busy`, `done` 0 immediately; after release, IDLE, new start runs normally.
- period 0xFFFFFFFF, step 0x80000000 -> duties 0x80000000, 0xFFFFFFFF (saturated), no wrap; without `PWM_BREATH_HOLD_EN`, no hold periods.
